// File: rtl/r4u3_stage_seq_if.sv
// ---------------------------------------------------------------------------
// r4u3_stage_seq_if
// Bundles the sample stream into and out of the radix-4 unit 3 stage
// sequencer.
//
// Handshake: a sample moves on a rising clk_sys edge when data_val_i=1.
// There is no ready signal, so the sink must accept every sample.
// frame_start_i is only meaningful when data_val_i=1. On the output side,
// data_val_o qualifies the data and sync outputs in the same cycle.
//
// Modports:
//   master : the stream source and result sink (the bench or upstream stage)
//   slave  : the sequencer itself
// Signals:
//   frame_start_i, data_val_i, data_real_i, data_imag_i, data_exp_i,
//   ldn_rg_i                              : upstream sample stream and size
//   block_sync_o, stage_sync_o, data_val_o,
//   data_real_o, data_imag_o, data_exp_o  : stream to the BF2 stage
//   ldn_rg_o, span_idx_o, busy_o          : frame status
//   frame_done_o, sync_err_o, cfg_err_o   : single-cycle event pulses
//   dbg_state_o                           : FSM state (0 = IDLE, 1 = RUN)
// ---------------------------------------------------------------------------
interface r4u3_stage_seq_if #(
   parameter int MAN_W = 16,
   parameter int EXP_W = 6
);
   logic             frame_start_i;
   logic             data_val_i;
   logic [MAN_W-1:0] data_real_i;
   logic [MAN_W-1:0] data_imag_i;
   logic [EXP_W-1:0] data_exp_i;
   logic [3:0]       ldn_rg_i;

   logic             block_sync_o;
   logic             stage_sync_o;
   logic             data_val_o;
   logic [MAN_W-1:0] data_real_o;
   logic [MAN_W-1:0] data_imag_o;
   logic [EXP_W-1:0] data_exp_o;
   logic [3:0]       ldn_rg_o;
   logic [3:0]       span_idx_o;
   logic             busy_o;
   logic             frame_done_o;
   logic             sync_err_o;
   logic             cfg_err_o;
   logic             dbg_state_o;

   modport master (
      output frame_start_i, data_val_i, data_real_i, data_imag_i, data_exp_i, ldn_rg_i,
      input  block_sync_o, stage_sync_o, data_val_o, data_real_o, data_imag_o, data_exp_o,
      input  ldn_rg_o, span_idx_o, busy_o, frame_done_o, sync_err_o, cfg_err_o, dbg_state_o
   );

   modport slave (
      input  frame_start_i, data_val_i, data_real_i, data_imag_i, data_exp_i, ldn_rg_i,
      output block_sync_o, stage_sync_o, data_val_o, data_real_o, data_imag_o, data_exp_o,
      output ldn_rg_o, span_idx_o, busy_o, frame_done_o, sync_err_o, cfg_err_o, dbg_state_o
   );
endinterface

// File: rtl/r4u3_stage_seq.sv
// ---------------------------------------------------------------------------
// r4u3_stage_seq
// Input sequencer for the radix-4 unit 3 butterfly stages of the pipeline
// FFT. It qualifies samples against a frame-start pulse and latches ldn once
// per frame. It cuts the frame into BF2 spans and registers the sample
// together with block_sync / stage_sync / data_val. Frame-start violations
// and unsupported sizes are flagged, and the frame is resynchronised.
//
// Ports:
//   clk_sys   : system clock, all logic on posedge
//   rst_sys_n : asynchronous active-low reset
//   bus       : r4u3_stage_seq_if.slave (sample stream in/out, status, pulses)
//
// All outputs are registered and appear one clk_sys after the input sample.
// Supported ldn is 8..11. The span is 512 for odd ldn and 256 for even ldn.
// ---------------------------------------------------------------------------
module r4u3_stage_seq #(
   parameter int MAN_W = 16,
   parameter int EXP_W = 6
) (
   input  logic             clk_sys,
   input  logic             rst_sys_n,
   r4u3_stage_seq_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [10:0]      samp_cnt_q, samp_cnt_d;
   logic [8:0]       span_cnt_q, span_cnt_d;
   logic [3:0]       ldn_q, ldn_d;
   logic [3:0]       span_idx_q, span_idx_d;
   logic             block_sync_q, block_sync_d;
   logic             stage_sync_q, stage_sync_d;
   logic             data_val_q, data_val_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic             sync_err_q, sync_err_d;
   logic             cfg_err_q, cfg_err_d;
   logic [MAN_W-1:0] data_real_q, data_real_d;
   logic [MAN_W-1:0] data_imag_q, data_imag_d;
   logic [EXP_W-1:0] data_exp_q, data_exp_d;

   logic             start_ev;
   logic             ldn_ok;
   logic [10:0]      last_samp;
   logic [8:0]       span_last;
   logic [3:0]       cur_idx;

   always_comb begin
      start_ev = bus.data_val_i & bus.frame_start_i;
      ldn_ok   = (bus.ldn_rg_i >= 4'd8) && (bus.ldn_rg_i <= 4'd11);

      // Index of the final sample (N-1) for the latched frame size.
      case (ldn_q)
         4'd8:    last_samp = 11'd255;
         4'd9:    last_samp = 11'd511;
         4'd10:   last_samp = 11'd1023;
         default: last_samp = 11'd2047;
      endcase

      // Odd ldn uses 512-sample spans and even ldn uses 256-sample spans.
      // The span index is samp_cnt shifted down by log2 of the span size.
      span_last = ldn_q[0] ? 9'd511 : 9'd255;
      cur_idx   = ldn_q[0] ? {2'b00, samp_cnt_q[10:9]} : {1'b0, samp_cnt_q[10:8]};

      state_d      = state_q;
      samp_cnt_d   = samp_cnt_q;
      span_cnt_d   = span_cnt_q;
      ldn_d        = ldn_q;
      span_idx_d   = span_idx_q;
      block_sync_d = 1'b0;
      stage_sync_d = 1'b0;
      data_val_d   = 1'b0;
      busy_d       = (state_q == RUN);
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      cfg_err_d    = 1'b0;
      data_real_d  = bus.data_val_i ? bus.data_real_i : '0;
      data_imag_d  = bus.data_val_i ? bus.data_imag_i : '0;
      data_exp_d   = bus.data_val_i ? bus.data_exp_i  : '0;

      if (start_ev) begin
         // A start during RUN is a violation. The frame is resynchronised
         // and never merged with the frame already in progress.
         sync_err_d = (state_q == RUN);
         if (ldn_ok) begin
            state_d      = RUN;
            ldn_d        = bus.ldn_rg_i;
            samp_cnt_d   = 11'd1;
            span_cnt_d   = 9'd1;
            span_idx_d   = 4'd0;
            block_sync_d = 1'b1;
            stage_sync_d = 1'b1;
            data_val_d   = 1'b1;
            busy_d       = 1'b1;
         end else begin
            cfg_err_d  = 1'b1;
            state_d    = IDLE;
            samp_cnt_d = 11'd0;
            span_cnt_d = 9'd0;
            busy_d     = 1'b0;
         end
      end else if (bus.data_val_i && (state_q == RUN)) begin
         data_val_d   = 1'b1;
         stage_sync_d = (span_cnt_q == 9'd0);
         span_idx_d   = cur_idx;
         samp_cnt_d   = samp_cnt_q + 11'd1;
         span_cnt_d   = (span_cnt_q == span_last) ? 9'd0 : span_cnt_q + 9'd1;
         if (samp_cnt_q == last_samp) begin
            // busy stays high for this output and drops on the next cycle
            // unless a new frame starts immediately.
            frame_done_d = 1'b1;
            state_d      = IDLE;
            samp_cnt_d   = 11'd0;
            span_cnt_d   = 9'd0;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state_q      <= IDLE;
         samp_cnt_q   <= '0;
         span_cnt_q   <= '0;
         ldn_q        <= '0;
         span_idx_q   <= '0;
         block_sync_q <= 1'b0;
         stage_sync_q <= 1'b0;
         data_val_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         cfg_err_q    <= 1'b0;
         data_real_q  <= '0;
         data_imag_q  <= '0;
         data_exp_q   <= '0;
      end else begin
         state_q      <= state_d;
         samp_cnt_q   <= samp_cnt_d;
         span_cnt_q   <= span_cnt_d;
         ldn_q        <= ldn_d;
         span_idx_q   <= span_idx_d;
         block_sync_q <= block_sync_d;
         stage_sync_q <= stage_sync_d;
         data_val_q   <= data_val_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
         cfg_err_q    <= cfg_err_d;
         data_real_q  <= data_real_d;
         data_imag_q  <= data_imag_d;
         data_exp_q   <= data_exp_d;
      end
   end

   assign bus.block_sync_o = block_sync_q;
   assign bus.stage_sync_o = stage_sync_q;
   assign bus.data_val_o   = data_val_q;
   assign bus.data_real_o  = data_real_q;
   assign bus.data_imag_o  = data_imag_q;
   assign bus.data_exp_o   = data_exp_q;
   assign bus.ldn_rg_o     = ldn_q;
   assign bus.span_idx_o   = span_idx_q;
   assign bus.busy_o       = busy_q;
   assign bus.frame_done_o = frame_done_q;
   assign bus.sync_err_o   = sync_err_q;
   assign bus.cfg_err_o    = cfg_err_q;
   assign bus.dbg_state_o  = state_q;

endmodule

// File: tb/tb_r4u3_stage_seq.sv
// ---------------------------------------------------------------------------
// tb_r4u3_stage_seq
// Self-checking bench for r4u3_stage_seq. The top of the test applies a
// table of single-cycle vectors for idle and size-error behaviour. Frame
// sequences follow: full frames, random gaps, back-to-back frames, a
// mid-frame restart, and reset during a frame. Expected outputs come from
// the sample index within the frame.
// ---------------------------------------------------------------------------
module tb_r4u3_stage_seq;
   localparam int MAN_W = 16;
   localparam int EXP_W = 6;

   // ---------------- clock / reset ----------------
   logic clk_sys = 1'b0;
   logic rst_sys_n = 1'b0;
   always #5 clk_sys = ~clk_sys;

   r4u3_stage_seq_if #(.MAN_W(MAN_W), .EXP_W(EXP_W)) bus ();

   r4u3_stage_seq #(.MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
      .clk_sys   (clk_sys),
      .rst_sys_n (rst_sys_n),
      .bus       (bus)
   );

   typedef struct packed {
      logic             dval;
      logic             bs;
      logic             ss;
      logic             done;
      logic             serr;
      logic             cerr;
      logic             busy;
      logic [3:0]       ldn;
      logic [3:0]       idx;
      logic [MAN_W-1:0] re;
      logic [MAN_W-1:0] im;
      logic [EXP_W-1:0] ex;
   } exp_t;

   typedef struct {
      logic             v;
      logic             fs;
      logic [3:0]       ldn;
      logic [MAN_W-1:0] re;
      logic [MAN_W-1:0] im;
      logic [EXP_W-1:0] ex;
      exp_t             e;
   } vec_t;

   // ---------------- scoreboard ----------------
   exp_t       exp_q[$];
   int         total = 0;
   int         bad = 0;
   logic [3:0] exp_ldn = 4'd0;
   logic [3:0] exp_idx = 4'd0;

   function automatic exp_t mk(input logic dv, input logic bs, input logic ss,
                               input logic done, input logic serr, input logic cerr,
                               input logic busy, input logic [3:0] ldn, input logic [3:0] idx,
                               input logic [MAN_W-1:0] re, input logic [MAN_W-1:0] im,
                               input logic [EXP_W-1:0] ex);
      return {dv, bs, ss, done, serr, cerr, busy, ldn, idx, re, im, ex};
   endfunction

   function automatic exp_t get_out();
      return {bus.data_val_o, bus.block_sync_o, bus.stage_sync_o, bus.frame_done_o,
              bus.sync_err_o, bus.cfg_err_o, bus.busy_o, bus.ldn_rg_o, bus.span_idx_o,
              bus.data_real_o, bus.data_imag_o, bus.data_exp_o};
   endfunction

   function automatic string fmt(input exp_t e);
      return $sformatf("dv=%0b bs=%0b ss=%0b fd=%0b se=%0b ce=%0b bz=%0b ldn=%0d idx=%0d re=%h im=%h ex=%h",
                       e.dval, e.bs, e.ss, e.done, e.serr, e.cerr, e.busy, e.ldn, e.idx,
                       e.re, e.im, e.ex);
   endfunction

   task automatic compare(input string nm);
      exp_t e;
      exp_t got;
      e   = exp_q.pop_front();
      got = get_out();
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL %s: got {%s} want {%s}", nm, fmt(got), fmt(e));
      end
   endtask

   // ---------------- driver ----------------
   // Drive one cycle of input, clock it, and check the registered outputs
   // 1 time unit after the edge.
   task automatic apply(input logic v, input logic fs, input logic [3:0] ldn,
                        input logic [MAN_W-1:0] re, input logic [MAN_W-1:0] im,
                        input logic [EXP_W-1:0] ex, input exp_t e, input string nm);
      bus.data_val_i    = v;
      bus.frame_start_i = fs;
      bus.ldn_rg_i      = ldn;
      bus.data_real_i   = re;
      bus.data_imag_i   = im;
      bus.data_exp_i    = ex;
      exp_q.push_back(e);
      @(posedge clk_sys);
      #1;
      compare(nm);
   endtask

   // Drive idle cycles with no valid data. frame_start_i and ldn toggle
   // randomly and must be ignored.
   task automatic idle(input int n, input logic busy_exp, input string nm);
      for (int i = 0; i < n; i++)
         apply(1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)), 16'hdead, 16'hbeef, 6'h2a,
               mk(0, 0, 0, 0, 0, 0, busy_exp, exp_ldn, exp_idx, '0, '0, '0), nm);
   endtask

   // Send samples 0..n_send-1 of a frame. Before each sample after the
   // first, insert gaps with a probability of (100-duty)%. serr0 marks a
   // start that lands in the middle of a running frame.
   task automatic frame(input int ldn, input int n_send, input int duty,
                        input logic serr0, input string nm);
      int               s;
      int               n;
      int               g;
      logic [MAN_W-1:0] re;
      logic [MAN_W-1:0] im;
      logic [EXP_W-1:0] ex;
      s = (ldn % 2 == 1) ? 512 : 256;
      n = 1 << ldn;
      for (int k = 0; k < n_send; k++) begin
         if (k > 0) begin
            g = 0;
            while (duty < 100 && int'($urandom_range(99)) >= duty && g < 20) begin
               idle(1, 1'b1, {nm, "_gap"});
               g++;
            end
         end
         re = 16'($urandom);
         im = 16'($urandom);
         ex = 6'($urandom);
         exp_ldn = 4'(ldn);
         exp_idx = 4'(k / s);
         apply(1'b1, k == 0, (k == 0) ? 4'(ldn) : 4'($urandom_range(15)), re, im, ex,
               mk(1, k == 0, (k % s) == 0, k == n - 1, (k == 0) && serr0, 0, 1,
                  4'(ldn), 4'(k / s), re, im, ex), nm);
      end
   endtask

   vec_t vecs[7];

   initial begin
      bus.data_val_i    = 1'b0;
      bus.frame_start_i = 1'b0;
      bus.ldn_rg_i      = 4'd0;
      bus.data_real_i   = '0;
      bus.data_imag_i   = '0;
      bus.data_exp_i    = '0;

      // ---- reset state ----
      repeat (2) @(posedge clk_sys);
      #1;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, '0, '0, '0));
      compare("reset_state");
      rst_sys_n = 1'b1;

      // ---- table: idle drops, ignored start without valid, bad sizes ----
      vecs[0] = '{1, 0, 4'd8,  16'h1234, 16'h5678, 6'h11, mk(0,0,0,0,0,0,0,4'd0,4'd0,16'h1234,16'h5678,6'h11)};
      vecs[1] = '{0, 1, 4'd8,  16'h1111, 16'h2222, 6'h01, mk(0,0,0,0,0,0,0,4'd0,4'd0,16'h0000,16'h0000,6'h00)};
      vecs[2] = '{1, 1, 4'd7,  16'h8000, 16'h7fff, 6'h20, mk(0,0,0,0,0,1,0,4'd0,4'd0,16'h8000,16'h7fff,6'h20)};
      vecs[3] = '{0, 0, 4'd7,  16'h3333, 16'h4444, 6'h05, mk(0,0,0,0,0,0,0,4'd0,4'd0,16'h0000,16'h0000,6'h00)};
      vecs[4] = '{1, 1, 4'd12, 16'hffff, 16'h0001, 6'h3f, mk(0,0,0,0,0,1,0,4'd0,4'd0,16'hffff,16'h0001,6'h3f)};
      vecs[5] = '{1, 1, 4'd15, 16'h0abc, 16'h0def, 6'h07, mk(0,0,0,0,0,1,0,4'd0,4'd0,16'h0abc,16'h0def,6'h07)};
      vecs[6] = '{1, 0, 4'd9,  16'h5a5a, 16'ha5a5, 6'h15, mk(0,0,0,0,0,0,0,4'd0,4'd0,16'h5a5a,16'ha5a5,6'h15)};
      for (int i = 0; i < 7; i++)
         apply(vecs[i].v, vecs[i].fs, vecs[i].ldn, vecs[i].re, vecs[i].im, vecs[i].ex,
               vecs[i].e, $sformatf("vec%0d", i));

      // ---- ldn=8 contiguous frame; busy drops after frame_done ----
      frame(8, 256, 100, 1'b0, "ldn8");
      idle(2, 1'b0, "ldn8_after");

      // ---- ldn=11 with 30% valid duty ----
      frame(11, 2048, 30, 1'b0, "ldn11_duty");
      idle(1, 1'b0, "ldn11_after");

      // ---- ldn=10 then ldn=9 back to back, no bubble ----
      frame(10, 1024, 100, 1'b0, "b2b_ldn10");
      frame(9, 512, 100, 1'b0, "b2b_ldn9");
      idle(1, 1'b0, "b2b_after");

      // ---- ldn=9 restarted at sample 300 ----
      frame(9, 300, 100, 1'b0, "restart_pre");
      frame(9, 512, 100, 1'b1, "restart_new");
      idle(1, 1'b0, "restart_after");

      // ---- reset at sample 100 of an ldn=11 frame ----
      frame(11, 100, 100, 1'b0, "rst_pre");
      rst_sys_n = 1'b0;
      #1;
      exp_ldn = 4'd0;
      exp_idx = 4'd0;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, '0, '0, '0));
      compare("rst_async");
      bus.data_val_i = 1'b1;
      @(posedge clk_sys);
      #1;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, '0, '0, '0));
      compare("rst_held");
      rst_sys_n = 1'b1;
      for (int i = 0; i < 3; i++)
         apply(1'b1, 1'b0, 4'd11, 16'h0100 + 16'(i), 16'h0200, 6'h03,
               mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 16'h0100 + 16'(i), 16'h0200, 6'h03),
               "rst_drop");
      frame(8, 256, 100, 1'b0, "rst_fresh");
      idle(1, 1'b0, "rst_fresh_after");

      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
